// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard hazard unit: 2-bit pending-write counters for 32 scalar and 32
// vector registers; stalls decode on RAW/overflow hazards and on drain.
// Ports: clk, rst (sync active-low); issue_valid, instr_rs1/rs2/rd,
//   use_rs1/rs2, src_vec, wr_scalar, wr_vec (decode side);
//   WRITEREGISTER_WB, WRITEREGISTERVEC_WB, RD_WB (writeback); drain_req;
//   outputs stall, issue_accept, drain_done, busy, underflow_err.
// Build option: define SCOREBOARD_BYPASS_EN to waive a source hazard when its
//   last pending write is being written back in the same cycle.
module scoreboard_hazard_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] instr_rs1,
  input  logic [4:0] instr_rs2,
  input  logic [4:0] instr_rd,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic       src_vec,
  input  logic       wr_scalar,
  input  logic       wr_vec,
  input  logic       WRITEREGISTER_WB,
  input  logic       WRITEREGISTERVEC_WB,
  input  logic [4:0] RD_WB,
  input  logic       drain_req,
  output logic       stall,
  output logic       issue_accept,
  output logic       drain_done,
  output logic       busy,
  output logic       underflow_err
);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_s_q [32];
  logic [1:0] cnt_s_d [32];
  logic [1:0] cnt_v_q [32];
  logic [1:0] cnt_v_d [32];
  logic       uf_q, uf_d;
  logic       dd_q, dd_d;

  logic [1:0] c1, c2;
  logic       wb_src;
  logic       haz1, haz2;
  logic       full_rd;
  logic       inc_s, inc_v;
  logic       all_zero_d;
  logic       busy_any;

  // Source counters come from the file selected by src_vec.
  always_comb begin
    c1     = src_vec ? cnt_v_q[instr_rs1] : cnt_s_q[instr_rs1];
    c2     = src_vec ? cnt_v_q[instr_rs2] : cnt_s_q[instr_rs2];
    wb_src = src_vec ? WRITEREGISTERVEC_WB : WRITEREGISTER_WB;
`ifdef SCOREBOARD_BYPASS_EN
    haz1 = use_rs1 && (c1 != 2'd0) &&
           !((c1 == 2'd1) && wb_src && (RD_WB == instr_rs1));
    haz2 = use_rs2 && (c2 != 2'd0) &&
           !((c2 == 2'd1) && wb_src && (RD_WB == instr_rs2));
`else
    haz1 = use_rs1 && (c1 != 2'd0);
    haz2 = use_rs2 && (c2 != 2'd0);
`endif
    full_rd = (wr_scalar && (cnt_s_q[instr_rd] == 2'd3)) ||
              (wr_vec && (cnt_v_q[instr_rd] == 2'd3));
  end

  assign stall = (state_q == DRAIN) || drain_req ||
                 haz1 || haz2 || full_rd;
  assign issue_accept = issue_valid && !stall;
  assign inc_s = issue_accept && wr_scalar;
  assign inc_v = issue_accept && wr_vec;

  // Coincident inc and dec cancel; a lone dec of zero is dropped and flagged.
  always_comb begin
    uf_d       = uf_q;
    all_zero_d = 1'b1;
    busy_any   = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic is, ds, iv, dv;
      is = inc_s && (instr_rd == 5'(i));
      ds = WRITEREGISTER_WB && (RD_WB == 5'(i));
      iv = inc_v && (instr_rd == 5'(i));
      dv = WRITEREGISTERVEC_WB && (RD_WB == 5'(i));
      cnt_s_d[i] = cnt_s_q[i];
      cnt_v_d[i] = cnt_v_q[i];
      if (is && !ds) begin
        if (cnt_s_q[i] != 2'd3) cnt_s_d[i] = cnt_s_q[i] + 2'd1;
      end else if (ds && !is) begin
        if (cnt_s_q[i] == 2'd0) uf_d = 1'b1;
        else cnt_s_d[i] = cnt_s_q[i] - 2'd1;
      end
      if (iv && !dv) begin
        if (cnt_v_q[i] != 2'd3) cnt_v_d[i] = cnt_v_q[i] + 2'd1;
      end else if (dv && !iv) begin
        if (cnt_v_q[i] == 2'd0) uf_d = 1'b1;
        else cnt_v_d[i] = cnt_v_q[i] - 2'd1;
      end
      if ((cnt_s_d[i] != 2'd0) || (cnt_v_d[i] != 2'd0))
        all_zero_d = 1'b0;
      if ((cnt_s_q[i] != 2'd0) || (cnt_v_q[i] != 2'd0))
        busy_any = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    dd_d    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (drain_req) state_d = DRAIN;
      end
      DRAIN: begin
        if (all_zero_d) begin
          state_d = RUN;
          dd_d    = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      uf_q    <= 1'b0;
      dd_q    <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        cnt_s_q[i] <= 2'd0;
        cnt_v_q[i] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      uf_q    <= uf_d;
      dd_q    <= dd_d;
      for (int i = 0; i < 32; i++) begin
        cnt_s_q[i] <= cnt_s_d[i];
        cnt_v_q[i] <= cnt_v_d[i];
      end
    end
  end

  assign busy          = busy_any;
  assign drain_done    = dd_q;
  assign underflow_err = uf_q;

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Bench for scoreboard_hazard_unit: directed vectors, literal checks, and a
// per-cycle comparison against a counter-array reference model.
module tb_scoreboard_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid;
  logic [4:0] instr_rs1, instr_rs2, instr_rd;
  logic       use_rs1, use_rs2, src_vec;
  logic       wr_scalar, wr_vec;
  logic       WRITEREGISTER_WB, WRITEREGISTERVEC_WB;
  logic [4:0] RD_WB;
  logic       drain_req;
  logic       stall, issue_accept, drain_done, busy, underflow_err;

  int total = 0;
  int bad   = 0;

  scoreboard_hazard_unit dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid),
    .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .src_vec(src_vec),
    .wr_scalar(wr_scalar), .wr_vec(wr_vec),
    .WRITEREGISTER_WB(WRITEREGISTER_WB),
    .WRITEREGISTERVEC_WB(WRITEREGISTERVEC_WB), .RD_WB(RD_WB),
    .drain_req(drain_req), .stall(stall), .issue_accept(issue_accept),
    .drain_done(drain_done), .busy(busy), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  // Reference model: pending-write counts per register, drain flag.
  int  ms [32];
  int  mv [32];
  bit  m_drain;
  bit  m_dd;
  bit  m_uf;
  bit  armed = 1'b0;

  function automatic bit src_hz(input bit use_r, input logic [4:0] r);
    int c;
    bit wb;
    if (!use_r) return 1'b0;
    c  = src_vec ? mv[r] : ms[r];
    wb = src_vec ? WRITEREGISTERVEC_WB : WRITEREGISTER_WB;
    if (c == 0) return 1'b0;
`ifdef SCOREBOARD_BYPASS_EN
    if (c == 1 && wb && RD_WB == r) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic bit m_stall();
    return m_drain || drain_req ||
           src_hz(use_rs1, instr_rs1) || src_hz(use_rs2, instr_rs2) ||
           (wr_scalar && ms[instr_rd] == 3) ||
           (wr_vec && mv[instr_rd] == 3);
  endfunction

  function automatic bit m_busy();
    for (int i = 0; i < 32; i++)
      if (ms[i] != 0 || mv[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        ms[i] = 0;
        mv[i] = 0;
      end
      m_drain = 0;
      m_dd    = 0;
      m_uf    = 0;
      armed   = 1'b1;
    end else if (armed) begin
      bit acc;
      acc = issue_valid && !m_stall();
      if (!(acc && wr_scalar && WRITEREGISTER_WB && instr_rd == RD_WB)) begin
        if (WRITEREGISTER_WB) begin
          if (ms[RD_WB] == 0) m_uf = 1;
          else ms[RD_WB] -= 1;
        end
        if (acc && wr_scalar) ms[instr_rd] += 1;
      end
      if (!(acc && wr_vec && WRITEREGISTERVEC_WB && instr_rd == RD_WB)) begin
        if (WRITEREGISTERVEC_WB) begin
          if (mv[RD_WB] == 0) m_uf = 1;
          else mv[RD_WB] -= 1;
        end
        if (acc && wr_vec) mv[instr_rd] += 1;
      end
      m_dd = m_drain && !m_busy();
      if (!m_drain && drain_req) m_drain = 1;
      else if (m_drain && !m_busy()) m_drain = 0;
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      bit s;
      s = m_stall();
      chk("m_stall", stall, s);
      chk("m_accept", issue_accept, issue_valid && !s);
      chk("m_busy", busy, m_busy());
      chk("m_drain_done", drain_done, m_dd);
      chk("m_underflow", underflow_err, m_uf);
    end
  end

  task automatic clr();
    issue_valid = 0; instr_rs1 = 0; instr_rs2 = 0; instr_rd = 0;
    use_rs1 = 0; use_rs2 = 0; src_vec = 0; wr_scalar = 0; wr_vec = 0;
    WRITEREGISTER_WB = 0; WRITEREGISTERVEC_WB = 0; RD_WB = 0;
    drain_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic iss_s(input logic [4:0] rd);
    clr(); issue_valid = 1; wr_scalar = 1; instr_rd = rd;
  endtask

  task automatic iss_v(input logic [4:0] rd);
    clr(); issue_valid = 1; wr_vec = 1; instr_rd = rd;
  endtask

  task automatic wb_s(input logic [4:0] r);
    clr(); WRITEREGISTER_WB = 1; RD_WB = r;
  endtask

  task automatic wb_v(input logic [4:0] r);
    clr(); WRITEREGISTERVEC_WB = 1; RD_WB = r;
  endtask

  initial begin
    clr();
    rst = 0;
    step(); step();
    rst = 1;
    settle();
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_dd", drain_done, 0);
    chk("rst_uf", underflow_err, 0);

    // RAW on scalar r5
    iss_s(5); settle();
    chk("raw_first_acc", issue_accept, 1);
    step();
    clr(); issue_valid = 1; use_rs1 = 1; instr_rs1 = 5; settle();
    chk("raw_stall", stall, 1);
    step(); step();
    WRITEREGISTER_WB = 1; RD_WB = 5; settle();
`ifdef SCOREBOARD_BYPASS_EN
    chk("raw_bypass_acc", issue_accept, 1);
    step();
    clr();
`else
    chk("raw_wb_acc", issue_accept, 0);
    step();
    WRITEREGISTER_WB = 0; settle();
    chk("raw_after_acc", issue_accept, 1);
    step();
    clr();
`endif
    step();

    // vector r3 saturates at three pending writes
    for (int k = 0; k < 3; k++) begin
      iss_v(3); settle();
      chk("v3_acc", issue_accept, 1);
      step();
    end
    iss_v(3); settle();
    chk("v3_full_stall", stall, 1);
    step();
    WRITEREGISTERVEC_WB = 1; RD_WB = 3; settle();
    chk("v3_wb_still", issue_accept, 0);
    step();
    WRITEREGISTERVEC_WB = 0; settle();
    chk("v3_acc_next", issue_accept, 1);
    step();
    for (int k = 0; k < 3; k++) begin
      wb_v(3); step();
    end
    clr(); settle();
    chk("v3_empty", busy, 0);

    // file selection: vector r12 pending does not block scalar r12 reads
    iss_v(12); step();
    clr(); issue_valid = 1; use_rs2 = 1; instr_rs2 = 12; src_vec = 1;
    settle();
    chk("vec_rs2_stall", stall, 1);
    src_vec = 0; settle();
    chk("sca_rs2_free", stall, 0);
    step();
    wb_v(12); step();

    // simultaneous inc and dec on scalar r7
    iss_s(7); step();
    iss_s(7); WRITEREGISTER_WB = 1; RD_WB = 7; settle();
    chk("r7_acc", issue_accept, 1);
    step();
    clr(); settle();
    chk("r7_busy", busy, 1);
    wb_s(7); step();
    clr(); settle();
    chk("r7_empty", busy, 0);

    // drain with pending scalar r2 and vector r9
    iss_s(2); step();
    iss_v(9); step();
    clr(); issue_valid = 1; drain_req = 1; settle();
    chk("drn_req_stall", stall, 1);
    step();
    clr(); settle();
    chk("drn_state_stall", stall, 1);
    step();
    wb_s(2); step();
    wb_v(9); settle();
    chk("drn_dd_low", drain_done, 0);
    step();
    clr(); settle();
    chk("drn_dd_pulse", drain_done, 1);
    chk("drn_run", stall, 0);
    step();
    chk("drn_dd_once", drain_done, 0);

    // empty drain passes through DRAIN for one cycle
    drain_req = 1; step();
    drain_req = 0; settle();
    chk("edrn_stall", stall, 1);
    chk("edrn_dd0", drain_done, 0);
    step();
    chk("edrn_dd1", drain_done, 1);
    step();

    // underflow is sticky
    wb_s(4); step();
    clr(); settle();
    chk("uf_set", underflow_err, 1);
    step(); step();
    chk("uf_sticky", underflow_err, 1);

    // reset mid-drain with pending write and a WB in the reset cycle
    iss_s(10); step();
    clr(); drain_req = 1; step();
    clr(); rst = 0; WRITEREGISTER_WB = 1; RD_WB = 10; step();
    clr(); rst = 1; settle();
    chk("mr_busy", busy, 0);
    chk("mr_stall", stall, 0);
    chk("mr_dd", drain_done, 0);
    chk("mr_uf", underflow_err, 0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-003 SHALL have port issue_valid, input, 1: decode presents an instruction this cycle.
REQ-004 SHALL have ports instr_rs1, instr_rs2, instr_rd, input, 5 each: source and destination register indices from the decode instruction fields.
REQ-005 SHALL have ports use_rs1, use_rs2, input, 1 each: the instruction reads that source.
REQ-006 SHALL have port src_vec, input, 1: sources read the vector file (1) or the scalar file (0).
REQ-007 SHALL have ports wr_scalar, wr_vec, input, 1 each: the instruction writes scalar rd or vector rd (WriteRegister / WriteRegisterVec).
REQ-008 SHALL have ports WRITEREGISTER_WB, WRITEREGISTERVEC_WB, input, 1 each, and RD_WB, input, 5: writeback completion.
REQ-009 SHALL have port drain_req, input, 1: request to empty the pipeline of pending writes.
REQ-010 SHALL have outputs stall (1), issue_accept (1), drain_done (1), busy (1) and underflow_err (1).

Function
REQ-011 SHALL keep one 2-bit pending-write counter per register: 32 scalar and 32 vector (64 total).
REQ-012 SHALL drive issue_accept = issue_valid & ~stall, combinationally.
REQ-013 SHALL assert stall (combinational) when any of the following holds:
- state is DRAIN, or drain_req=1;
- use_rs1 and the counter for rs1 in the file selected by src_vec is nonzero;
- the same condition holds for rs2;
- wr_scalar and the scalar counter[rd] is 3;
- wr_vec and the vector counter[rd] is 3.
REQ-014 On issue_accept, SHALL increment the counter for rd in each file whose write flag is set.
REQ-015 On a WB strobe, SHALL decrement the counter for RD_WB in the corresponding file; both strobes in one cycle update both files.
REQ-016 SHALL leave a counter unchanged when an increment and a decrement hit it in the same cycle.
REQ-017 SHALL ignore a decrement of a zero counter, leave that counter at 0, and set underflow_err (sticky until reset).
REQ-018 SHALL never wrap a counter past 3; stall guarantees no increment occurs at 3.
REQ-019 SHALL drive busy = 1 iff any counter is nonzero, registered-state based with no input path.
REQ-020 FSM states SHALL be RUN and DRAIN, with these transitions:
- RUN to DRAIN on drain_req=1;
- DRAIN to RUN on the edge where all counters are 0 after this cycle's updates;
- drain_req in DRAIN is ignored.
REQ-021 SHALL pulse drain_done high for exactly one cycle, registered, in the cycle after DRAIN exits to RUN.
REQ-022 drain_req=1 with an empty scoreboard SHALL still pass through DRAIN for one cycle, so drain_done rises 2 cycles after the request.

Reset
REQ-023 With rst=0 at a clock edge, SHALL set all counters to 0, state to RUN, and drain_done and underflow_err to 0; hence busy=0.
REQ-024 Reset mid-drain or with pending writes SHALL discard all state; any WB strobe in the reset cycle is ignored.

Configuration
REQ-025 Macro SCOREBOARD_BYPASS_EN SHALL control same-cycle writeback bypass.
- Defined: a source hazard is waived when its counter equals 1 and the matching-file WB strobe with RD_WB equal to that source is high in the same cycle.
- Undefined: that case stalls for one extra cycle.
- All other behaviour is identical in both builds.

Verification
REQ-026 Reset, then issue wr_scalar rd=5, then issue use_rs1 rs1=5 scalar -> second issue stalls until the WB for scalar r5; issue_accept follows in the cycle after the WB (same cycle if SCOREBOARD_BYPASS_EN).
REQ-027 Issue wr_vec rd=3 three times with no WB, then a fourth -> the fourth stalls (counter=3); one vector WB for rd=3 -> the fourth is accepted the next cycle.
REQ-028 Scalar counter[7]=1; issue wr_scalar rd=7 together with WRITEREGISTER_WB RD_WB=7 -> counter stays 1 and busy stays 1.
REQ-029 Two pending writes (scalar r2, vector r9), then drain_req -> stall=1 from the request cycle; after both WBs drain_done pulses once; stall drops in RUN.
REQ-030 WRITEREGISTER_WB RD_WB=4 with counter 0 -> underflow_err=1 and stays 1 until rst=0.
REQ-031 Assert rst=0 during DRAIN with pending writes -> next cycle: busy=0, stall=0, drain_done=0, state RUN.
